// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Adds two 4*NIBBLES-bit operands plus a carry in, one nibble per clock,
// through one 4-bit full-adder stage (full_adder_4bit_st). The carry out of
// each nibble is registered and fed back as the carry in of the next nibble.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are 1. The producer holds a_i/b_i/cin_i while in_valid_i is
// high and in_ready_o is low. The result (s_o, cout_o, ovf_o) is held stable
// while out_valid_o is high and out_ready_i is low. Both ready and valid
// outputs are decodes of the state register only.
//
// Optional feature macro: NSA_OVERFLOW_EN
//   defined   -> ovf_o reports signed overflow of the full-width sum
//   undefined -> ovf_o is tied to 0 and no overflow logic exists
//
// Ports:
//   clk_i         clock, all state changes on rising edge
//   rst_i         synchronous active-high reset
//   in_valid_i    operand set valid
//   in_ready_o    block can accept operands (IDLE)
//   a_i, b_i      operands, 4*NIBBLES bits, sampled on accept
//   cin_i         initial carry in, sampled on accept
//   out_valid_o   result valid (DONE)
//   out_ready_i   consumer takes result
//   s_o           sum, meaningful while out_valid_o=1
//   cout_o        carry out of the most significant nibble
//   ovf_o         signed overflow (see macro above)
//   busy_o        high in ADD or DONE
//   dbg_state_o   current FSM state (0=IDLE, 1=ADD, 2=DONE)
// ---------------------------------------------------------------------------

// Single 4-bit full-adder stage: {c_o, s_o} = a_i + b_i + c_i.
module full_adder_4bit_st (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [4*NIBBLES-1:0]   a_i,
    input  logic [4*NIBBLES-1:0]   b_i,
    input  logic                   cin_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [4*NIBBLES-1:0]   s_o,
    output logic                   cout_o,
    output logic                   ovf_o,
    output logic                   busy_o,
    output logic [1:0]             dbg_state_o
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      s_q;
    logic              carry_q;
    logic              cout_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [3:0]        sum4;
    logic              stage_c;
    logic              last_nib;

    // Bit offset of the current nibble; idx never exceeds NIBBLES-1.
    always_comb begin
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = b_q[{idx_q, 2'b00} +: 4];
    end

    full_adder_4bit_st u_stage (
        .a_i (nib_a),
        .b_i (nib_b),
        .c_i (carry_q),
        .s_o (sum4),
        .c_o (stage_c)
    );

    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));
    assign idx_d    = idx_q + 1'b1;

`ifdef NSA_OVERFLOW_EN
    logic ovf_q;
    logic msb_carry_in;
    // Carry into bit 3 of the stage recovered from the sum bit:
    // s3 = a3 ^ b3 ^ c3  =>  c3 = a3 ^ b3 ^ s3.
    assign msb_carry_in = nib_a[3] ^ nib_b[3] ^ sum4[3];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef NSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready is 1 throughout IDLE, so in_valid alone is an accept.
                    if (in_valid_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= cin_i;
                        idx_q   <= '0;
                        s_q     <= '0;
                        cout_q  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    s_q[{idx_q, 2'b00} +: 4] <= sum4;
                    carry_q                  <= stage_c;
                    if (last_nib) begin
                        // idx stays at NIBBLES-1 rather than wrapping.
                        cout_q  <= stage_c;
`ifdef NSA_OVERFLOW_EN
                        ovf_q   <= msb_carry_in ^ stage_c;
`endif
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign s_o         = s_q;
    assign cout_o      = cout_q;
    assign dbg_state_o = state_q;
`ifdef NSA_OVERFLOW_EN
    assign ovf_o       = ovf_q;
`else
    assign ovf_o       = 1'b0;
`endif

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-precision adder that adds two NIBBLES×4-bit operands one nibble per clock through a single full_adder_4bit_st stage. The carry out of each nibble is registered and fed back as the carry in of the next nibble. The block sits directly upstream of the 4-bit full-adder stage: it sequences operand nibbles into that stage and collects its sum and carry into a wide result. Valid/ready handshakes on both sides let it drop into datapaths that need wider sums than the 4-bit stage provides.

## Interface
- NIBBLES, 4: operand width in nibbles; operand width W = 4×NIBBLES; legal range 1..16.

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- a  in  W  operand A, sampled on accept
- b  in  W  operand B, sampled on accept
- cin  in  1  initial carry in, sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- s  out  W  sum, meaningful only while out_valid=1
- cout  out  1  carry out of the most significant nibble
- ovf  out  1  signed overflow; see Configuration
- busy  out  1  high in ADD or DONE

## Operation
- States:
  - IDLE: in_ready=1.
  - ADD: nibble loop.
  - DONE: result held.
- IDLE→ADD on accept (in_valid & in_ready):
  - latch a, b into operand registers
  - carry ← cin, idx ← 0, s ← 0, cout ← 0, ovf ← 0
- ADD, each cycle:
  - the stage computes {c, sum4} = a[idx] + b[idx] + carry, with all nibbles 4 bits wide
  - s[4·idx+3:4·idx] ← sum4, carry ← c, idx ← idx+1
- ADD→DONE on the edge that writes nibble NIBBLES−1. On that edge, cout ← c.
- DONE→IDLE on out_valid & out_ready.
- DONE holds s, cout and ovf stable for any number of cycles while out_ready=0.
- in_ready=0 in ADD and DONE. in_valid is ignored there; no operands are queued or dropped silently, and the producer must hold them.
- Result is exact: {cout, s} = a + b + cin, modulo 2^(W+1).
- NIBBLES=1 degenerates to one ADD cycle.

## Timing
- Reset values, effective on the first edge with rst=1:
  - state=IDLE, in_ready=1, out_valid=0, busy=0
  - s=0, cout=0, ovf=0, carry=0, idx=0
- Reset in ADD or DONE aborts the operation. The partial result is discarded and no out_valid pulse follows.
- rst has priority over simultaneous in_valid or out_ready.
- Accept at edge E0 → out_valid=1 from edge E0+NIBBLES.
- Output handshake at edge Eh → in_ready=1 from Eh; earliest next accept at Eh+1.
- Minimum issue interval is NIBBLES+2 cycles. There is no overlap of operations.
- in_ready and out_valid are registered state decodes, with no combinational path from in_valid or out_ready.
- idx is ceil(log2(NIBBLES)) bits wide (minimum 1) and never wraps past NIBBLES−1.

## Configuration
- NSA_OVERFLOW_EN defined:
  - on the final nibble, ovf ← (carry into bit W−1) XOR (carry out of bit W−1)
  - this requires the MSB-internal carry from the final nibble
  - ovf is valid with out_valid and held in DONE
- NSA_OVERFLOW_EN undefined:
  - ovf is tied to 0
  - no overflow logic is generated
  - the port list is unchanged

## Test plan
- NIBBLES=4; a=0xFFFF, b=0x0001, cin=0 → s=0x0000, cout=1. out_valid rises exactly 4 cycles after the accept edge.
- a=0x1234, b=0x4321, cin=1 → s=0x5556, cout=0.
- a=0x7FFF, b=0x0001, cin=0 → s=0x8000, cout=0. ovf=1 with NSA_OVERFLOW_EN, 0 without.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → s, cout and ovf are stable, in_ready=0, and the new operands are not accepted. Raising out_ready gives in_ready=1 on the next cycle, and the pending operands are accepted one cycle later.
- rst asserted 2 cycles into ADD → next cycle: state IDLE, out_valid=0, in_ready=1, s=0. No stale result appears afterwards.
- NIBBLES=1, exhaustive sweep of all 512 {cin, b, a} combinations, issued back to back with out_ready=1 → {cout, s} = a+b+cin every time, at an issue interval of 3 cycles.
